// File: rtl/multiplier_sa.sv
// Sequential shift-and-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Iterates only over the significant bits of the multiplier (two cycles per bit).
module multiplier_sa #(
  parameter int unsigned BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BITS-1:0]   multiplicand,
  input  logic [BITS-1:0]   multiplier,
  input  logic [BITS-1:0]   addend,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] product
);

  localparam int unsigned CntW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StAdd   = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e              state;
  logic [2*BITS-1:0]   acc;
  logic [2*BITS-1:0]   mcand;
  logic [BITS-1:0]     mplier;
  logic [CntW-1:0]     count;
  logic [CntW-1:0]     b_len;

  // Bit length of the incoming multiplier: index of the highest set bit plus one.
  always_comb begin
    b_len = '0;
    for (int i = 0; i < BITS; i++) begin
      if (multiplier[i]) b_len = CntW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            acc    <= {{BITS{1'b0}}, addend};
            mcand  <= {{BITS{1'b0}}, multiplicand};
            mplier <= multiplier;
            count  <= b_len;
            busy   <= 1'b1;
            state  <= StCheck;
          end
        end
        StCheck: begin
          state <= (count == '0) ? StDone : StAdd;
        end
        StAdd: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          state  <= StCheck;
        end
        StDone: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_multiplier_sa.sv
// Directed scoreboard bench for multiplier_sa: expected product and latency are queued at
// issue time and checked when done pulses.
module tb_multiplier_sa;

  localparam int unsigned BITS = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [BITS-1:0]   multiplicand;
  logic [BITS-1:0]   multiplier;
  logic [BITS-1:0]   addend;
  logic              busy;
  logic              done;
  logic [2*BITS-1:0] product;

  typedef struct {
    logic [2*BITS-1:0] prod;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  multiplier_sa #(.BITS(BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bit_len(input logic [BITS-1:0] b);
    int n = 0;
    for (int i = 0; i < BITS; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Drive one start that is sampled on the next edge; operands are scrambled afterwards.
  task automatic issue(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic [BITS-1:0] c);
    exp_t e;
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = BITS'($urandom);
    multiplier   = BITS'($urandom);
    addend       = BITS'($urandom);
    e.prod = (2*BITS)'(a) * (2*BITS)'(b) + (2*BITS)'(c);
    e.lat  = 2 * bit_len(b) + 2;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done; 'already' is the number of edges elapsed since the start edge.
  task automatic wait_done(input string tag, input int already);
    int   cyc;
    exp_t e;
    cyc = already;
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'(cyc), 64'd0);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_product"}, 64'(product), 64'(e.prod));
      check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int    seen;
    logic [BITS-1:0] ra, rb, rc;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    step();
    step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    reset = 1'b0;

    // Zero multiplier.
    issue(16'h1234, 16'h0000, 16'h0007);
    check("zero_prod_const", 64'(sb[0].prod), 64'h7);
    wait_done("zero_mult", 0);
    step();
    check("done_one_cycle", 64'(done), 64'd0);

    // Divider round-trip, with busy observed mid-operation.
    issue(16'd7, 16'd14, 16'd2);
    step();
    check("busy_mid_op", 64'(busy), 64'd1);
    wait_done("div_trip", 1);
    check("div_trip_value", 64'(product), 64'h64);
    step();
    check("product_held", 64'(product), 64'h64);

    // Full-scale with an ignored start held for 10 cycles, then back-to-back start.
    issue(16'hFFFF, 16'hFFFF, 16'hFFFF);
    step();
    step();
    multiplicand = 16'h0005;
    multiplier   = 16'h0003;
    addend       = 16'h0001;
    start        = 1'b1;
    for (int i = 0; i < 10; i++) step();
    start = 1'b0;
    wait_done("full_scale", 12);
    check("full_scale_value", 64'(product), 64'hFFFF0000);
    issue(16'd2, 16'd3, 16'd1);
    wait_done("back_to_back", 0);
    check("back_to_back_value", 64'(product), 64'h7);

    // Reset mid-operation: no later done pulse.
    issue(16'd3, 16'h8000, 16'd0);
    sb.delete();
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Start sampled on the first edge after reset deasserts.
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(16'd100, 16'd200, 16'd300);
    wait_done("first_after_reset", 0);
    check("first_after_reset_value", 64'(product), 64'd20300);

    // A few random operations.
    for (int k = 0; k < 6; k++) begin
      ra = BITS'($urandom);
      rb = BITS'($urandom) >> $urandom_range(0, BITS - 1);
      rc = BITS'($urandom);
      issue(ra, rb, rc);
      wait_done("random", 0);
      step();
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
